// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: bundles the command, ALU, result and preload buses
// of alu_issue_stage.
//   cmd_*  : command handshake and fields (valid/ready)
//   alu_*  : operand/function outputs to the ALU, y/z returned from it
//   res_*  : result handshake and payload (valid/ready)
//   ld_*   : external register preload
// slave is the stage side, master the environment side.
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_f;
  logic [AW-1:0]    cmd_rs;
  logic [AW-1:0]    cmd_rt;
  logic [AW-1:0]    cmd_rd;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_z;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic [AW-1:0]    res_rd;

  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;

  modport slave (
    input  cmd_valid, cmd_f, cmd_rs, cmd_rt, cmd_rd, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_f,
    input  alu_y, alu_z,
    output res_valid, res_data, res_zero, res_rd,
    input  res_ready,
    input  ld_en, ld_addr, ld_data
  );

  modport master (
    output cmd_valid, cmd_f, cmd_rs, cmd_rt, cmd_rd, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_f,
    output alu_y, alu_z,
    input  res_valid, res_data, res_zero, res_rd,
    output res_ready,
    output ld_en, ld_addr, ld_data
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register file plus ACCEPT -> EX -> RES pipeline in front
// of an external combinational ALU.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_issue_stage_if.slave (command, ALU, result, preload buses)
// EX registers drive alu_a/b/f directly; the ALU result is captured into RES
// and written back to reg[rd] on the same edge. EX results are forwarded to
// the operand read so dependent commands issue back to back.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);

  logic [WIDTH-1:0] regs [NREG];
  logic             ex_valid;
  logic [AW-1:0]    ex_rd;

  logic             ex_adv;
  logic             accept;
  logic             wb_en;
  logic             ld_we;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // EX moves into RES whenever RES is empty or being drained this cycle
  assign ex_adv        = ex_valid && (!bus.res_valid || bus.res_ready);
  assign bus.cmd_ready = rst_n && (!ex_valid || ex_adv);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign wb_en         = ex_adv && (ex_rd != '0);
  // preload loses to a writeback aimed at the same register
  assign ld_we         = bus.ld_en && (bus.ld_addr != '0) &&
                         !(wb_en && (ex_rd == bus.ld_addr));

  // Operand read: r0, then EX forward, then same-cycle preload, then file
  function automatic logic [WIDTH-1:0] read_op(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (ex_adv && (ex_rd == addr)) begin
      val = bus.alu_y;
    end else if (bus.ld_en && (bus.ld_addr == addr)) begin
      val = bus.ld_data;
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  // Operand selection for the command being offered
  always_comb begin
    op_a = read_op(bus.cmd_rs);
    op_b = bus.cmd_use_imm ? bus.cmd_imm : read_op(bus.cmd_rt);
  end

  // Register file: preload and writeback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_we) begin
        regs[bus.ld_addr] <= bus.ld_data;
      end
      if (wb_en) begin
        regs[ex_rd] <= bus.alu_y;
      end
    end
  end

  // EX stage: holds the ALU inputs until the entry advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_f <= 3'b000;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      ex_rd     <= bus.cmd_rd;
      bus.alu_a <= op_a;
      bus.alu_b <= op_b;
      bus.alu_f <= bus.cmd_f;
    end else if (ex_adv) begin
      ex_valid  <= 1'b0;
    end
  end

  // RES stage: captures the ALU result when EX advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_rd    <= '0;
    end else if (ex_adv) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= bus.alu_y;
      bus.res_zero  <= bus.alu_z;
      bus.res_rd    <= ex_rd;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule
